apb_timer_target: RTL and testbench
===================================

APB_TIMER_TARGET -- requirements
Module: apb_timer_target

Interface
REQ-001 SHALL have clock input `clk`, 1 bit, rising-edge clock for all state.
REQ-002 SHALL have reset input `reset_n`, 1 bit, asynchronous, active-low.
REQ-003 SHALL have input `apb_request__paddr`, 32 bits, APB address; bits [4:2] select the register and bits [11:5] must be zero.
REQ-004 SHALL have inputs `apb_request__psel`, `apb_request__penable` and `apb_request__pwrite`, 1 bit each, the APB control signals.
REQ-005 SHALL have input `apb_request__pwdata`, 32 bits, APB write data.
REQ-006 SHALL have output `apb_response__prdata`, 32 bits, read data.
REQ-007 SHALL have output `apb_response__pready`, 1 bit, transfer complete.
REQ-008 SHALL have output `apb_response__perr`, 1 bit, error on an undecoded offset.
REQ-009 SHALL have output `timer_irq`, 1 bit, level interrupt.

Function
REQ-010 SHALL treat `psel=1` with `penable=0` as setup and `psel=1` with `penable=1` as access; register writes commit only on the access-phase clock edge.
REQ-011 SHALL drive `pready=1` in every cycle, giving zero wait states; each transfer is therefore two cycles.
REQ-012 SHALL drive `prdata` combinationally from the decoded register whenever `psel=1`, and drive it to 0 otherwise.
REQ-013 SHALL use this register map, selected by `paddr[4:2]`:
- 0x00 CTRL: bit0 = enable, bit1 = irq_en, bit2 = wrap_on_match.
- 0x04 COUNT: read/write.
- 0x08 COMPARE: read/write.
- 0x0C STATUS: bit0 = match, write-1-to-clear.
REQ-014 SHALL, for any undecoded offset, assert `perr=1` in the access phase, return `prdata=0`, and leave all state unchanged.
REQ-015 SHALL ignore CTRL write bits [31:3] and read them as 0.
REQ-016 SHALL generate a tick every cycle in which enable=1, subject to REQ-024 when the prescaler is built in.
REQ-017 SHALL, on a tick, set COUNT to 0 when COUNT==COMPARE and wrap_on_match=1; otherwise it SHALL set COUNT to COUNT+1, modulo 2^32, so 0xFFFFFFFF wraps to 0.
REQ-018 SHALL set STATUS.match on the edge of any tick where COUNT==COMPARE before the update.
REQ-019 SHALL give a software COUNT write priority over a same-cycle tick increment; the match check still uses the pre-write COUNT.
REQ-020 SHALL let the set win when a STATUS W1C write coincides with a new match in the same cycle.
REQ-021 SHALL drive `timer_irq = STATUS.match AND irq_en`, combinationally from registers.

Reset
REQ-022 SHALL, with `reset_n=0`, clear CTRL, COUNT, COMPARE, STATUS and PRESCALE (when present) to 0, giving `timer_irq=0`, `pready=1`, `perr=0` and `prdata=0` while `psel=0`.
REQ-023 SHALL treat reset asserted mid-transfer or mid-count as an abort: no partial write persists and counting resumes only once software sets enable again.

Configuration
REQ-024 SHALL, with `APB_TIMER_PRESCALER_EN` defined, add register 0x10 PRESCALE (8 bits, read/write) and an 8-bit divider, issuing a tick once every PRESCALE+1 enabled cycles; the divider SHALL reset to 0 on a PRESCALE write or when enable=0.
REQ-025 SHALL, without `APB_TIMER_PRESCALER_EN`, tick every enabled cycle and treat offset 0x10 as undecoded (`perr=1`).

Structure
REQ-026 SHALL place the register offset constants, the CTRL bit positions and the 3-bit register-select enum in the shared package `apb_timer_pkg`.
REQ-027 SHALL be a single module with no sub-modules; the prescaler is inline logic under the macro.

Verification
REQ-028 SHALL verify a write of COMPARE=5 and CTRL=0x3, which must give STATUS.match=1 and `timer_irq=1` on the tick where COUNT is 5, with COUNT reading 6 afterwards.
REQ-029 SHALL verify CTRL=0x5 with COMPARE=3, which must give the COUNT sequence 0,1,2,3,0,1 with match set once per wrap.
REQ-030 SHALL verify a COUNT write of 0x100 in a tick cycle, which must read back exactly 0x100.
REQ-031 SHALL verify COUNT preloaded to 0xFFFFFFFF with COMPARE=0 and wrap_on_match=0, which must read 0 on the next tick and set match on the following tick.
REQ-032 SHALL verify a STATUS write of 1 coinciding with a match, which must leave match=1; a later write of 1 must clear it and drop `timer_irq`.
REQ-033 SHALL verify an access to 0x14, and to 0x10 in a build without the macro, which must return `perr=1` and `prdata=0` with all registers unchanged.

Source files
------------

// File: rtl/apb_timer_pkg.sv
// rtl/apb_timer_pkg.sv - shared register map, CTRL bit positions and register-select enum for the APB timer
package apb_timer_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned CTRL_W     = 3;
  localparam int unsigned PRESCALE_W = 8;

  // Byte offsets within the 4 KiB target window; only bits [11:0] take part in decode
  localparam logic [11:0] CTRL_OFFSET     = 12'h000;
  localparam logic [11:0] COUNT_OFFSET    = 12'h004;
  localparam logic [11:0] COMPARE_OFFSET  = 12'h008;
  localparam logic [11:0] STATUS_OFFSET   = 12'h00C;
  localparam logic [11:0] PRESCALE_OFFSET = 12'h010;

  // CTRL bit positions
  localparam int unsigned CTRL_ENABLE_BIT = 0;
  localparam int unsigned CTRL_IRQ_EN_BIT = 1;
  localparam int unsigned CTRL_WRAP_BIT   = 2;

  // STATUS bit positions
  localparam int unsigned STATUS_MATCH_BIT = 0;

  // Register select, equal to paddr[4:2] of the decoded offset
  typedef enum logic [2:0] {
    REG_CTRL     = 3'd0,
    REG_COUNT    = 3'd1,
    REG_COMPARE  = 3'd2,
    REG_STATUS   = 3'd3,
    REG_PRESCALE = 3'd4
  } reg_sel_e;

  // Word-aligned view of an APB address inside the target window
  function automatic logic [11:0] word_offset(input logic [31:0] addr);
    return {addr[11:2], 2'b00};
  endfunction

endpackage

// File: rtl/apb_timer_target_if.sv
// rtl/apb_timer_target_if.sv - APB request/response bundle for the timer target
interface apb_timer_target_if;

  logic [31:0] apb_request__paddr;
  logic        apb_request__psel;
  logic        apb_request__penable;
  logic        apb_request__pwrite;
  logic [31:0] apb_request__pwdata;

  logic [31:0] apb_response__prdata;
  logic        apb_response__pready;
  logic        apb_response__perr;

  modport master (
    output apb_request__paddr,
    output apb_request__psel,
    output apb_request__penable,
    output apb_request__pwrite,
    output apb_request__pwdata,
    input  apb_response__prdata,
    input  apb_response__pready,
    input  apb_response__perr
  );

  modport slave (
    input  apb_request__paddr,
    input  apb_request__psel,
    input  apb_request__penable,
    input  apb_request__pwrite,
    input  apb_request__pwdata,
    output apb_response__prdata,
    output apb_response__pready,
    output apb_response__perr
  );

endinterface

// File: rtl/apb_timer_target.sv
// rtl/apb_timer_target.sv - APB timer with compare/match interrupt; APB_TIMER_PRESCALER_EN adds PRESCALE at 0x10
module apb_timer_target
  import apb_timer_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset_n,
  apb_timer_target_if.slave        apb,
  output logic                     timer_irq
);

  // Register state
  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] count_q;
  logic [DATA_W-1:0] compare_q;
  logic              match_q;

  // Decode
  logic [11:0]       offset;
  reg_sel_e          sel;
  logic              sel_valid;
  logic              access;
  logic              wr_en;
  logic              wr_ctrl;
  logic              wr_count;
  logic              wr_compare;
  logic              wr_status;
  logic [DATA_W-1:0] rdata;

  // Counting
  logic              enable;
  logic              irq_en;
  logic              wrap_on_match;
  logic              tick;
  logic              count_hit;

  // Address bits outside the decoded window carry no meaning for this target
  logic              unused_addr_bits;
  assign unused_addr_bits = ^{apb.apb_request__paddr[31:12], apb.apb_request__paddr[1:0]};

  assign offset = word_offset(apb.apb_request__paddr);

  // Map the word offset to a register select; anything else is undecoded
  always_comb begin
    sel       = REG_CTRL;
    sel_valid = 1'b1;
    case (offset)
      CTRL_OFFSET:     sel = REG_CTRL;
      COUNT_OFFSET:    sel = REG_COUNT;
      COMPARE_OFFSET:  sel = REG_COMPARE;
      STATUS_OFFSET:   sel = REG_STATUS;
`ifdef APB_TIMER_PRESCALER_EN
      PRESCALE_OFFSET: sel = REG_PRESCALE;
`endif
      default:         sel_valid = 1'b0;
    endcase
  end

  assign access     = apb.apb_request__psel & apb.apb_request__penable;
  assign wr_en      = access & apb.apb_request__pwrite & sel_valid;
  assign wr_ctrl    = wr_en && (sel == REG_CTRL);
  assign wr_count   = wr_en && (sel == REG_COUNT);
  assign wr_compare = wr_en && (sel == REG_COMPARE);
  assign wr_status  = wr_en && (sel == REG_STATUS);

  assign enable        = ctrl_q[CTRL_ENABLE_BIT];
  assign irq_en        = ctrl_q[CTRL_IRQ_EN_BIT];
  assign wrap_on_match = ctrl_q[CTRL_WRAP_BIT];
  assign count_hit     = (count_q == compare_q);

`ifdef APB_TIMER_PRESCALER_EN
  logic              wr_prescale;
  logic [PRESCALE_W-1:0] prescale_q;
  logic [PRESCALE_W-1:0] div_q;

  assign wr_prescale = wr_en && (sel == REG_PRESCALE);

  // PRESCALE register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prescale_q <= '0;
    end else if (wr_prescale) begin
      prescale_q <= apb.apb_request__pwdata[PRESCALE_W-1:0];
    end
  end

  // Divider restarts on a PRESCALE write or while disabled and wraps on each issued tick
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= '0;
    end else if (wr_prescale || !enable) begin
      div_q <= '0;
    end else if (div_q == prescale_q) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + PRESCALE_W'(1);
    end
  end

  assign tick = enable && (div_q == prescale_q);
`else
  assign tick = enable;
`endif

  // CTRL register; bits above the defined fields are dropped on write
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q <= '0;
    end else if (wr_ctrl) begin
      ctrl_q <= apb.apb_request__pwdata[CTRL_W-1:0];
    end
  end

  // COUNT: a software write beats a same-cycle tick; a tick wraps to 0 on match or counts up
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (wr_count) begin
      count_q <= apb.apb_request__pwdata;
    end else if (tick) begin
      if (count_hit && wrap_on_match) begin
        count_q <= '0;
      end else begin
        count_q <= count_q + 32'd1;
      end
    end
  end

  // COMPARE register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      compare_q <= '0;
    end else if (wr_compare) begin
      compare_q <= apb.apb_request__pwdata;
    end
  end

  // STATUS.match: a new match on a tick wins over a coincident write-1-to-clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      match_q <= 1'b0;
    end else if (tick && count_hit) begin
      match_q <= 1'b1;
    end else if (wr_status && apb.apb_request__pwdata[STATUS_MATCH_BIT]) begin
      match_q <= 1'b0;
    end
  end

  // Read mux: the decoded register while selected, zero otherwise
  always_comb begin
    rdata = '0;
    if (apb.apb_request__psel && sel_valid) begin
      case (sel)
        REG_CTRL:     rdata = {{(DATA_W-CTRL_W){1'b0}}, ctrl_q};
        REG_COUNT:    rdata = count_q;
        REG_COMPARE:  rdata = compare_q;
        REG_STATUS:   rdata = {{(DATA_W-1){1'b0}}, match_q};
`ifdef APB_TIMER_PRESCALER_EN
        REG_PRESCALE: rdata = {{(DATA_W-PRESCALE_W){1'b0}}, prescale_q};
`endif
        default:      rdata = '0;
      endcase
    end
  end

  assign apb.apb_response__prdata = rdata;
  assign apb.apb_response__pready = 1'b1;
  assign apb.apb_response__perr   = access & ~sel_valid;

  assign timer_irq = match_q & irq_en;

endmodule

// File: tb/tb_apb_timer_target.sv
// tb/tb_apb_timer_target.sv - scoreboard bench for apb_timer_target
module tb_apb_timer_target;

  localparam logic [31:0] A_CTRL  = 32'h00;
  localparam logic [31:0] A_COUNT = 32'h04;
  localparam logic [31:0] A_CMP   = 32'h08;
  localparam logic [31:0] A_STAT  = 32'h0C;
  localparam logic [31:0] A_PRE   = 32'h10;

  logic clk = 1'b0;
  logic reset_n;
  logic timer_irq;

  apb_timer_target_if bus ();

  apb_timer_target dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .apb       (bus),
    .timer_irq (timer_irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          chk_data;
    logic [31:0] data;
    logic        perr;
    bit          chk_irq;
    logic        irq;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Monitor: every access phase out of reset consumes one scoreboard entry
  always @(negedge clk) begin
    if (reset_n === 1'b1 && bus.apb_request__psel === 1'b1 && bus.apb_request__penable === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_access: addr 0x%08h with no expectation queued", bus.apb_request__paddr);
      end else begin
        mon_e = exp_q.pop_front();
        check({mon_e.name, "_pready"}, {31'd0, bus.apb_response__pready}, 32'd1);
        check({mon_e.name, "_perr"}, {31'd0, bus.apb_response__perr}, {31'd0, mon_e.perr});
        if (mon_e.chk_data) check({mon_e.name, "_prdata"}, bus.apb_response__prdata, mon_e.data);
        if (mon_e.chk_irq) check({mon_e.name, "_irq"}, {31'd0, timer_irq}, {31'd0, mon_e.irq});
      end
    end
  end

  task automatic push(input string n, input bit cd, input logic [31:0] d, input logic pe,
                      input bit ci, input logic irq);
    exp_t e;
    e.name = n; e.chk_data = cd; e.data = d; e.perr = pe; e.chk_irq = ci; e.irq = irq;
    exp_q.push_back(e);
  endtask

  // Two-cycle transfer; entered and left at 1 time unit after a rising edge
  task automatic xfer(input bit w, input logic [31:0] a, input logic [31:0] d);
    bus.apb_request__psel    = 1'b1;
    bus.apb_request__penable = 1'b0;
    bus.apb_request__pwrite  = w;
    bus.apb_request__paddr   = a;
    bus.apb_request__pwdata  = d;
    @(posedge clk); #1;
    bus.apb_request__penable = 1'b1;
    @(posedge clk); #1;
    bus.apb_request__psel    = 1'b0;
    bus.apb_request__penable = 1'b0;
    bus.apb_request__pwrite  = 1'b0;
  endtask

  task automatic wr(input string n, input logic [31:0] a, input logic [31:0] d);
    push(n, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    xfer(1'b1, a, d);
  endtask

  task automatic rd(input string n, input logic [31:0] a, input logic [31:0] exp);
    push(n, 1'b1, exp, 1'b0, 1'b0, 1'b0);
    xfer(1'b0, a, 32'd0);
  endtask

  task automatic rdi(input string n, input logic [31:0] a, input logic [31:0] exp, input logic irq);
    push(n, 1'b1, exp, 1'b0, 1'b1, irq);
    xfer(1'b0, a, 32'd0);
  endtask

  task automatic bad(input string n, input bit w, input logic [31:0] a);
    push(n, 1'b1, 32'd0, 1'b1, 1'b0, 1'b0);
    xfer(w, a, 32'hFFFF_FFFF);
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    bus.apb_request__psel    = 1'b0;
    bus.apb_request__penable = 1'b0;
    bus.apb_request__pwrite  = 1'b0;
    bus.apb_request__paddr   = 32'd0;
    bus.apb_request__pwdata  = 32'd0;

    // Reset outputs while idle
    repeat (2) @(negedge clk);
    check("rst_pready", {31'd0, bus.apb_response__pready}, 32'd1);
    check("rst_perr",   {31'd0, bus.apb_response__perr}, 32'd0);
    check("rst_prdata", bus.apb_response__prdata, 32'd0);
    check("rst_irq",    {31'd0, timer_irq}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    rd("rst_ctrl", A_CTRL, 32'd0);
    rd("rst_count", A_COUNT, 32'd0);
    rd("rst_cmp", A_CMP, 32'd0);
    rd("rst_stat", A_STAT, 32'd0);

    // Match at COUNT=5 with irq enabled; CTRL=2 lands on the tick that matches
    wr("t1_cmp", A_CMP, 32'd5);
    wr("t1_ctrl", A_CTRL, 32'h3);
    rd("t1_count1", A_COUNT, 32'd1);
    rdi("t1_stat0", A_STAT, 32'd0, 1'b0);
    wr("t1_stop", A_CTRL, 32'h2);
    rd("t1_count6", A_COUNT, 32'd6);
    rdi("t1_stat1", A_STAT, 32'd1, 1'b1);
    rd("t1_ctrl_rb", A_CTRL, 32'h2);

    // Wrap on match, COMPARE=3: sequence 0,1,2,3,0,1,...
    wr("t2_ctrl0", A_CTRL, 32'h0);
    wr("t2_clr", A_STAT, 32'h1);
    wr("t2_count", A_COUNT, 32'd0);
    wr("t2_cmp", A_CMP, 32'd3);
    rdi("t2_stat_clr", A_STAT, 32'd0, 1'b0);
    wr("t2_go", A_CTRL, 32'h5);
    rd("t2_c1", A_COUNT, 32'd1);
    rd("t2_c3", A_COUNT, 32'd3);
    rd("t2_c1b", A_COUNT, 32'd1);
    rd("t2_match1", A_STAT, 32'd1);
    wr("t2_w1c", A_STAT, 32'h1);
    rd("t2_match0", A_STAT, 32'd0);
    rd("t2_match2", A_STAT, 32'd1);
    wr("t2_stop", A_CTRL, 32'h0);
    wr("t2b_clr", A_STAT, 32'h1);
    wr("t2b_count", A_COUNT, 32'd0);
    rd("t2b_c0", A_COUNT, 32'd0);
    wr("t2b_go", A_CTRL, 32'h5);
    idle();
    rd("t2b_c2", A_COUNT, 32'd2);
    rd("t2b_c0w", A_COUNT, 32'd0);
    rd("t2b_c2b", A_COUNT, 32'd2);
    wr("t2b_stop", A_CTRL, 32'h0);

    // COUNT write coinciding with a tick wins; one tick elapses before the read
    wr("t3_clr", A_STAT, 32'h1);
    wr("t3_cmp", A_CMP, 32'h0000_FFFF);
    wr("t3_count", A_COUNT, 32'h10);
    wr("t3_go", A_CTRL, 32'h1);
    wr("t3_load", A_COUNT, 32'h100);
    rd("t3_c101", A_COUNT, 32'h101);
    wr("t3_stop", A_CTRL, 32'h0);
    rd("t3_c104", A_COUNT, 32'h104);
    wr("t3_load_idle", A_COUNT, 32'h100);
    rd("t3_c100", A_COUNT, 32'h100);

    // 0xFFFFFFFF wraps to 0 with wrap_on_match=0, then matches COMPARE=0
    wr("t4_clr", A_STAT, 32'h1);
    wr("t4_cmp", A_CMP, 32'd0);
    wr("t4_count", A_COUNT, 32'hFFFF_FFFF);
    wr("t4_go", A_CTRL, 32'h1);
    rd("t4_c0", A_COUNT, 32'd0);
    rdi("t4_match", A_STAT, 32'd1, 1'b0);
    wr("t4_stop", A_CTRL, 32'h0);

    // W1C coinciding with a match: set wins; a later W1C clears and drops irq
    wr("t5_clr", A_STAT, 32'h1);
    wr("t5_cmp", A_CMP, 32'd4);
    wr("t5_count", A_COUNT, 32'd0);
    wr("t5_go", A_CTRL, 32'h3);
    idle();
    rd("t5_c2", A_COUNT, 32'd2);
    wr("t5_w1c_hit", A_STAT, 32'h1);
    wr("t5_stop", A_CTRL, 32'h2);
    rdi("t5_kept", A_STAT, 32'd1, 1'b1);
    rd("t5_c7", A_COUNT, 32'd7);
    wr("t5_w1c", A_STAT, 32'h1);
    rdi("t5_cleared", A_STAT, 32'd0, 1'b0);

    // Undecoded offsets: perr, zero read data, no state change
    wr("t6_ctrl", A_CTRL, 32'hFFFF_FFFE);
    wr("t6_count", A_COUNT, 32'h1234);
    wr("t6_cmp", A_CMP, 32'h55);
    bad("t6_w14", 1'b1, 32'h14);
    bad("t6_r14", 1'b0, 32'h14);
    bad("t6_w20", 1'b1, 32'h20);
    bad("t6_r84", 1'b0, 32'h84);
`ifdef APB_TIMER_PRESCALER_EN
    wr("t6_pre", A_PRE, 32'hFFFF_FFFF);
    rd("t6_pre_rb", A_PRE, 32'hFF);
`else
    bad("t6_w10", 1'b1, A_PRE);
    bad("t6_r10", 1'b0, A_PRE);
`endif
    rd("t6_ctrl_rb", A_CTRL, 32'h6);
    rd("t6_count_rb", A_COUNT, 32'h1234);
    rd("t6_cmp_rb", A_CMP, 32'h55);
    rdi("t6_stat_rb", A_STAT, 32'd0, 1'b0);

    // Reset during the access phase of a COUNT write aborts it and stops counting
    wr("t7_go", A_CTRL, 32'h1);
    bus.apb_request__psel    = 1'b1;
    bus.apb_request__penable = 1'b0;
    bus.apb_request__pwrite  = 1'b1;
    bus.apb_request__paddr   = A_COUNT;
    bus.apb_request__pwdata  = 32'h77;
    @(posedge clk); #1;
    bus.apb_request__penable = 1'b1;
    #2 reset_n = 1'b0;
    @(posedge clk); #1;
    bus.apb_request__psel    = 1'b0;
    bus.apb_request__penable = 1'b0;
    bus.apb_request__pwrite  = 1'b0;
    reset_n = 1'b1;
    rd("t7_count", A_COUNT, 32'd0);
    rd("t7_ctrl", A_CTRL, 32'd0);
    idle();
    rd("t7_count_idle", A_COUNT, 32'd0);
    rd("t7_cmp", A_CMP, 32'd0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations never observed, required 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
